instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the immediate sign-extender: owns the PC and drives the

---
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues req/ack fetches to instruction memory and holds one word for decode.
// Latency: instr_valid one cycle after imem_ack; at most one instruction per two cycles.
// Backpressure: instr_ready low parks in HOLD with no request issued; redirects override ack and ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic        redirect_jalr,
    input  logic [31:0] redirect_base,
    input  logic [31:0] imm_ext,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] pend;
    logic [31:0] target;
    logic        tgt_bad;
    logic        take;

    always_comb begin
        target = redirect_base + imm_ext;
        if (redirect_jalr)
            target[0] = 1'b0;
    end

    assign tgt_bad = |target[1:0];
    // Once halted on a misaligned target, further redirects are ignored until reset.
    assign take    = redirect && !misalign_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (misalign_err || (take && tgt_bad))
                    state_nxt = IDLE;
                else
                    state_nxt = FETCH;
            end
            FETCH: begin
                if (take) begin
                    if (!imem_ack)
                        state_nxt = DRAIN;
                    else
                        state_nxt = tgt_bad ? IDLE : FETCH;
                end else if (imem_ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (take)
                    state_nxt = tgt_bad ? IDLE : FETCH;
                else if (instr_ready)
                    state_nxt = FETCH;
            end
            DRAIN: begin
                if (imem_ack)
                    state_nxt = (misalign_err || (take && tgt_bad)) ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pc is only advanced on ack, so it doubles as the in-flight address while draining.
    always_comb begin
        imem_req  = (state == FETCH) || (state == DRAIN);
        imem_addr = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            pend         <= RESET_PC;
            instr        <= NOP_INSTR;
            instr_pc     <= 32'h0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (take && tgt_bad)
                misalign_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (take && !tgt_bad)
                        pc <= target;
                end
                FETCH: begin
                    if (take) begin
                        if (!imem_ack)
                            pend <= target;
                        else if (!tgt_bad)
                            pc <= target;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (take || instr_ready) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (take && !tgt_bad)
                            pc <= target;
                    end
                end
                DRAIN: begin
                    if (take)
                        pend <= target;
                    if (imem_ack && !misalign_err && !(take && tgt_bad))
                        pc <= take ? target : pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized fetch/redirect traffic against an address/data model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic        redirect_jalr = 1'b0;
    logic [31:0] redirect_base = 32'h0;
    logic [31:0] imm_ext = 32'h0;
    logic        misalign_err;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_jalr(redirect_jalr),
        .redirect_base(redirect_base), .imm_ext(imm_ext),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_err"}, {31'h0, misalign_err}, 32'h0);
    endtask

    // Random aligned target: JALR cases use an odd base so the bit-0 clear matters.
    task automatic mk_target(output logic [31:0] t);
        logic [31:0] b, im;
        logic        j;
        b  = $urandom & 32'hFFFF_FFFC;
        im = $urandom & 32'hFFFF_FFFC;
        j  = 1'($urandom_range(0, 1));
        if (j)
            b = b | 32'h1;
        redirect_base = b;
        imm_ext       = im;
        redirect_jalr = j;
        t = b + im;
        if (j)
            t = t & 32'hFFFF_FFFE;
    endtask

    task automatic rand_fetch();
        logic [31:0] a, d, t;
        int          dly, k, h, n;
        n = 0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        chk("rnd_req_up", {31'h0, imem_req}, 32'h1);
        a = imem_addr;
        chk("rnd_addr", a, exp_pc);
        dly = $urandom_range(0, 3);
        d   = $urandom;
        k   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dly) : -1;
        mk_target(t);
        for (int c = 0; c <= dly; c++) begin
            imem_ack   = (c == dly);
            imem_rdata = d;
            redirect   = (c == k);
            step();
            imem_ack = 1'b0;
            redirect = 1'b0;
            if (c < dly) begin
                chk("rnd_req_held", {31'h0, imem_req}, 32'h1);
                chk("rnd_addr_held", imem_addr, a);
            end
        end
        if (k >= 0) begin
            exp_pc = t;
            chk("rnd_drop_valid", {31'h0, instr_valid}, 32'h0);
        end else begin
            exp_pc = a + 32'd4;
            chk("rnd_valid", {31'h0, instr_valid}, 32'h1);
            chk("rnd_instr", instr, d);
            chk("rnd_instr_pc", instr_pc, a);
            chk("rnd_hold_req", {31'h0, imem_req}, 32'h0);
            h = $urandom_range(0, 3);
            for (int i = 0; i < h; i++) begin
                step();
                chk("rnd_hold_instr", instr, d);
                chk("rnd_hold_valid", {31'h0, instr_valid}, 32'h1);
                chk("rnd_hold_req", {31'h0, imem_req}, 32'h0);
            end
            if ($urandom_range(0, 3) == 0) begin
                mk_target(t);
                redirect = 1'b1;
                step();
                redirect = 1'b0;
                exp_pc = t;
                chk("rnd_flush_valid", {31'h0, instr_valid}, 32'h0);
                chk("rnd_flush_instr", instr, NOP);
            end else begin
                instr_ready = 1'b1;
                step();
                instr_ready = 1'b0;
                chk("rnd_consume_valid", {31'h0, instr_valid}, 32'h0);
            end
        end
    endtask

    initial begin
        redirect_jalr = 1'b0;
        #12;
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;

        // Basic fetch after reset release
        step();
        chk("t1_req", {31'h0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 1'b0;
        chk("t1_valid", {31'h0, instr_valid}, 32'h1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_instr_pc", instr_pc, 32'h0);
        chk("t1_req_hold", {31'h0, imem_req}, 32'h0);

        // Downstream stall
        repeat (5) begin
            step();
            chk("t2_instr", instr, 32'h0050_0093);
            chk("t2_instr_pc", instr_pc, 32'h0);
            chk("t2_valid", {31'h0, instr_valid}, 32'h1);
            chk("t2_req", {31'h0, imem_req}, 32'h0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t1_next_req", {31'h0, imem_req}, 32'h1);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_consumed", {31'h0, instr_valid}, 32'h0);

        // Redirect while holding: flush and refetch from 0x10 - 8
        imem_ack = 1'b1; imem_rdata = 32'h0010_0113;
        step();
        imem_ack = 1'b0;
        chk("t3_pre_valid", {31'h0, instr_valid}, 32'h1);
        chk("t3_pre_pc", instr_pc, 32'h4);
        redirect_base = 32'h10; imm_ext = 32'hFFFF_FFF8; redirect = 1'b1;
        step();
        redirect = 1'b0;
        chk("t3_valid", {31'h0, instr_valid}, 32'h0);
        chk("t3_instr", instr, NOP);
        chk("t3_req", {31'h0, imem_req}, 32'h1);
        chk("t3_addr", imem_addr, 32'h8);

        // Redirect coinciding with ack: data dropped, refetch immediately
        redirect_base = 32'h20; imm_ext = 32'h0; redirect = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("ra_valid", {31'h0, instr_valid}, 32'h0);
        chk("ra_req", {31'h0, imem_req}, 32'h1);
        chk("ra_addr", imem_addr, 32'h20);

        // Redirect with request outstanding: address held until the late ack
        redirect_base = 32'h80; imm_ext = 32'h80; redirect = 1'b1;
        step();
        redirect = 1'b0;
        chk("t4_req_a", {31'h0, imem_req}, 32'h1);
        chk("t4_addr_a", imem_addr, 32'h20);
        step();
        chk("t4_addr_b", imem_addr, 32'h20);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("t4_valid", {31'h0, instr_valid}, 32'h0);
        chk("t4_req", {31'h0, imem_req}, 32'h1);
        chk("t4_addr", imem_addr, 32'h100);

        exp_pc = 32'h100;
        repeat (40) rand_fetch();

        // PC wrap at the top of the address space, then reset mid-request
        chk("t6_req_pre", {31'h0, imem_req}, 32'h1);
        redirect_base = 32'hFFFF_FFF0; imm_ext = 32'hC; redirect_jalr = 1'b0;
        redirect = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
        step();
        imem_ack = 1'b0;
        chk("t6_instr_pc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t6_wrap_req", {31'h0, imem_req}, 32'h1);
        chk("t6_wrap_addr", imem_addr, 32'h0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_rst");
        imem_ack = 1'b1;
        step();
        rst = 1'b0;
        step();
        imem_ack = 1'b0;
        chk("t6_late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("t6_restart_req", {31'h0, imem_req}, 32'h1);
        chk("t6_restart_addr", imem_addr, 32'h0);

        // Misaligned JALR target while holding: halt
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_ack = 1'b0;
        chk("t5_pre_valid", {31'h0, instr_valid}, 32'h1);
        redirect_base = 32'h1003; imm_ext = 32'h4; redirect_jalr = 1'b1; redirect = 1'b1;
        step();
        redirect = 1'b0; redirect_jalr = 1'b0;
        chk("t5_err", {31'h0, misalign_err}, 32'h1);
        chk("t5_req", {31'h0, imem_req}, 32'h0);
        chk("t5_valid", {31'h0, instr_valid}, 32'h0);
        redirect_base = 32'h40; imm_ext = 32'h0;
        repeat (5) begin
            redirect = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            step();
            chk("t5_halt_req", {31'h0, imem_req}, 32'h0);
            chk("t5_halt_err", {31'h0, misalign_err}, 32'h1);
        end
        redirect = 1'b0; imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_err", {31'h0, misalign_err}, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("t5_resume_req", {31'h0, imem_req}, 32'h1);
        chk("t5_resume_addr", imem_addr, 32'h0);

        // Misaligned target with request outstanding: drain first, then halt
        redirect_base = 32'h2; imm_ext = 32'h0; redirect = 1'b1;
        step();
        redirect = 1'b0;
        chk("mis_drain_err", {31'h0, misalign_err}, 32'h1);
        chk("mis_drain_req", {31'h0, imem_req}, 32'h1);
        chk("mis_drain_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        step();
        imem_ack = 1'b0;
        chk("mis_halt_req", {31'h0, imem_req}, 32'h0);
        chk("mis_halt_valid", {31'h0, instr_valid}, 32'h0);
        step();
        chk("mis_halt_req2", {31'h0, imem_req}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
